// File: rtl/uart_frame_parser.sv
// Sync-led X/Y position frame parser fed by a UART receiver's done flag.
// Define FRAME_CHECKSUM_EN to append and check a mod-256 checksum byte.
module uart_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE = 8'hAA,
  parameter logic [15:0] TIMEOUT   = 16'd2000
) (
  input  logic        fast_tick,
  input  logic        reset,
  input  logic [7:0]  d_in,
  input  logic        rx_done_tick,
  output logic [15:0] x_pos,
  output logic [15:0] y_pos,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  localparam logic [2:0] S_SYNC = 3'd0;
  localparam logic [2:0] S_XH   = 3'd1;
  localparam logic [2:0] S_XL   = 3'd2;
  localparam logic [2:0] S_YH   = 3'd3;
  localparam logic [2:0] S_YL   = 3'd4;
`ifdef FRAME_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd5;
`endif

  logic [2:0]  state_q, state_d;
  logic        prev_q;
  logic [15:0] gap_q, gap_d;
  logic [15:0] xs_q, xs_d;
  logic [15:0] ys_q, ys_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic        fv_q, fv_d;
  logic        fe_q, fe_d;
  logic [7:0]  ec_q, ec_d;
  logic        strobe;

  assign strobe = rx_done_tick & ~prev_q;

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = xs_q[15:8] + xs_q[7:0]
              + ys_q[15:8] + ys_q[7:0];
`endif

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    x_d     = x_q;
    y_d     = y_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    ec_d    = ec_q;
    if (strobe) begin
      // a strobe always beats a coincident timeout
      gap_d = 16'd0;
      unique case (state_q)
        S_SYNC: begin
          if (d_in == SYNC_BYTE) state_d = S_XH;
        end
        S_XH: begin
          xs_d[15:8] = d_in;
          state_d    = S_XL;
        end
        S_XL: begin
          xs_d[7:0] = d_in;
          state_d   = S_YH;
        end
        S_YH: begin
          ys_d[15:8] = d_in;
          state_d    = S_YL;
        end
`ifdef FRAME_CHECKSUM_EN
        S_YL: begin
          ys_d[7:0] = d_in;
          state_d   = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_SYNC;
          if (csum == d_in) begin
            x_d  = xs_q;
            y_d  = ys_q;
            fv_d = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end
`else
        S_YL: begin
          ys_d[7:0] = d_in;
          x_d       = xs_q;
          y_d       = {ys_q[15:8], d_in};
          fv_d      = 1'b1;
          state_d   = S_SYNC;
        end
`endif
        default: state_d = S_SYNC;
      endcase
    end else if (state_q != S_SYNC) begin
      if (gap_q == TIMEOUT) begin
        state_d = S_SYNC;
        gap_d   = 16'd0;
        xs_d    = 16'd0;
        ys_d    = 16'd0;
        fe_d    = 1'b1;
      end else begin
        gap_d = gap_q + 16'd1;
      end
    end else begin
      gap_d = 16'd0;
    end
    if (fe_d && ec_q != 8'hFF) ec_d = ec_q + 8'd1;
  end

  always_ff @(posedge fast_tick or negedge reset) begin
    if (!reset) begin
      state_q <= S_SYNC;
      prev_q  <= 1'b1;
      gap_q   <= 16'd0;
      xs_q    <= 16'd0;
      ys_q    <= 16'd0;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
      ec_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      prev_q  <= rx_done_tick;
      gap_q   <= gap_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
      ec_q    <= ec_d;
    end
  end

  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign err_cnt     = ec_q;

endmodule
